mult_control_gen: RTL and testbench

MULT_CONTROL_GEN -- requirements
Module: mult_control_gen

---
 rtl/mult_control_gen.sv | 181 ++++++++++++++++++
 tb/tb_mult_control_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_control_gen.sv
// rtl/mult_control_gen.sv - sequencing controller for a digit-serial multiplier
//
// Purpose:
//   Steps a DIG_W x DIG_W combinational sub-multiplier across every digit pair
//   of two DATA_W-bit operands. A start rise clears the accumulator for one
//   cycle. The controller then walks NDIG^2 partial products, pulses done, and
//   returns to idle. A second rise during an operation aborts it into ERR.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset_a    in   asynchronous active-low reset
//   start      in   operation request; only the 0->1 transition matters
//   a_sel      out  operand A digit index for the current partial product
//   b_sel      out  operand B digit index for the current partial product
//   shift_sel  out  partial-product shift in digits (a_sel + b_sel)
//   clk_ena    out  accumulator/datapath enable (CLR and CALC)
//   sclr_n     out  synchronous accumulator clear, active-low (CLR only)
//   done       out  one-cycle result-valid pulse
//   busy       out  high in CLR and CALC
//   err        out  high in ERR
//   state_out  out  IDLE=0, CLR=1, CALC=2, DONE=3, ERR=4

module mult_control_gen #(
  parameter  int DATA_W = 8,
  parameter  int DIG_W  = 4,
  localparam int NDIG   = DATA_W / DIG_W,
  localparam int IDX_W  = ($clog2(NDIG) < 1) ? 1 : $clog2(NDIG),
  localparam int SH_W   = ($clog2(2 * NDIG - 1) < 1) ? 1 : $clog2(2 * NDIG - 1)
) (
  input  logic             clk,
  input  logic             reset_a,
  input  logic             start,
  output logic [IDX_W-1:0] a_sel,
  output logic [IDX_W-1:0] b_sel,
  output logic [SH_W-1:0]  shift_sel,
  output logic             clk_ena,
  output logic             sclr_n,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic [2:0]       state_out
);

  if ((NDIG < 2) || (NDIG * DIG_W != DATA_W)) begin : g_bad_params
    $error("mult_control_gen: DATA_W must be a multiple of DIG_W with at least two digits");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    CALC = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  // The step counter k is held as two mixed-radix fields, k = kb*NDIG + ka,
  // so the digit selects fall straight out of the counter without a divider.
  state_t           state_q, state_d;
  logic [IDX_W-1:0] ka_q, ka_d;
  logic [IDX_W-1:0] kb_q, kb_d;
  logic             start_q, start_d;

  logic [IDX_W-1:0] a_sel_q, a_sel_d;
  logic [IDX_W-1:0] b_sel_q, b_sel_d;
  logic [SH_W-1:0]  shift_sel_q, shift_sel_d;
  logic             clk_ena_q, clk_ena_d;
  logic             sclr_n_q, sclr_n_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             rise;

  assign rise = start & ~start_q;

  always_comb begin
    start_d = start;
    state_d = state_q;
    ka_d    = ka_q;
    kb_d    = kb_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = CLR;
          ka_d    = '0;
          kb_d    = '0;
        end
      end
      CLR: begin
        if (rise) state_d = ERR;
        else      state_d = CALC;
      end
      CALC: begin
        // Abort wins over stepping; k stays where it was for inspection.
        if (rise) begin
          state_d = ERR;
        end else if (ka_q == LAST_IDX) begin
          ka_d = '0;
          if (kb_q == LAST_IDX) state_d = DONE;
          else                  kb_d    = kb_q + 1'b1;
        end else begin
          ka_d = ka_q + 1'b1;
        end
      end
      DONE: begin
        // A rise in the done cycle starts the next operation back-to-back.
        if (rise) begin
          state_d = CLR;
          ka_d    = '0;
          kb_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ERR: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state and next k, which gives
    // Moore outputs aligned with state_out without any path from start.
    clk_ena_d   = (state_d == CLR) || (state_d == CALC);
    busy_d      = (state_d == CLR) || (state_d == CALC);
    sclr_n_d    = (state_d != CLR);
    done_d      = (state_d == DONE);
    err_d       = (state_d == ERR);
    a_sel_d     = '0;
    b_sel_d     = '0;
    shift_sel_d = '0;
    if (state_d == CALC) begin
      a_sel_d     = ka_d;
      b_sel_d     = kb_d;
      shift_sel_d = SH_W'(ka_d) + SH_W'(kb_d);
    end
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q     <= IDLE;
      ka_q        <= '0;
      kb_q        <= '0;
      start_q     <= 1'b0;
      a_sel_q     <= '0;
      b_sel_q     <= '0;
      shift_sel_q <= '0;
      clk_ena_q   <= 1'b0;
      sclr_n_q    <= 1'b1;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ka_q        <= ka_d;
      kb_q        <= kb_d;
      start_q     <= start_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      shift_sel_q <= shift_sel_d;
      clk_ena_q   <= clk_ena_d;
      sclr_n_q    <= sclr_n_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign a_sel     = a_sel_q;
  assign b_sel     = b_sel_q;
  assign shift_sel = shift_sel_q;
  assign clk_ena   = clk_ena_q;
  assign sclr_n    = sclr_n_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_mult_control_gen.sv
// tb/tb_mult_control_gen.sv - self-checking bench for mult_control_gen (8-bit and 16-bit instances)

module tb_mult_control_gen;

  logic       clk;
  logic       reset_a;
  logic       start;

  logic [0:0] a8, b8;
  logic [1:0] sh8;
  logic       ena8, sclr8, done8, busy8, err8;
  logic [2:0] st8;

  logic [1:0] a16, b16;
  logic [2:0] sh16;
  logic       ena16, sclr16, done16, busy16, err16;
  logic [2:0] st16;

  mult_control_gen dut8 (
    .clk(clk), .reset_a(reset_a), .start(start),
    .a_sel(a8), .b_sel(b8), .shift_sel(sh8), .clk_ena(ena8), .sclr_n(sclr8),
    .done(done8), .busy(busy8), .err(err8), .state_out(st8)
  );

  mult_control_gen #(.DATA_W(16), .DIG_W(4)) dut16 (
    .clk(clk), .reset_a(reset_a), .start(start),
    .a_sel(a16), .b_sel(b16), .shift_sel(sh16), .clk_ena(ena16), .sclr_n(sclr16),
    .done(done16), .busy(busy16), .err(err16), .state_out(st16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sh;
    logic       ena;
    logic       sclr_n;
    logic       done;
    logic       busy;
    logic       err;
  } out_t;

  typedef struct {
    logic s;
    out_t exp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  out_t IDL, CL, DN, ER;

  // Reference model: an accepted rise lays down the whole future output
  // schedule; each clock edge consumes one entry.
  out_t m_sched [2][$];
  out_t m_cur [2];
  bit   m_err [2];
  logic m_prev;

  function automatic out_t rec(int st, int a, int b, int sh,
                               bit ena, bit scl, bit dn, bit bs, bit er);
    out_t o;
    o.st = 3'(st); o.a = 8'(a); o.b = 8'(b); o.sh = 8'(sh);
    o.ena = ena; o.sclr_n = scl; o.done = dn; o.busy = bs; o.err = er;
    return o;
  endfunction

  function automatic out_t calc_rec(int a, int b);
    return rec(2, a, b, a + b, 1, 1, 0, 1, 0);
  endfunction

  function automatic out_t dut_out(int d);
    out_t o;
    if (d == 0) begin
      o.st = st8; o.a = 8'(a8); o.b = 8'(b8); o.sh = 8'(sh8);
      o.ena = ena8; o.sclr_n = sclr8; o.done = done8; o.busy = busy8; o.err = err8;
    end else begin
      o.st = st16; o.a = 8'(a16); o.b = 8'(b16); o.sh = 8'(sh16);
      o.ena = ena16; o.sclr_n = sclr16; o.done = done16; o.busy = busy16; o.err = err16;
    end
    return o;
  endfunction

  task automatic chk(input string name, input out_t got, input out_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got st=%0d a=%0d b=%0d sh=%0d ena=%0b sclr_n=%0b done=%0b busy=%0b err=%0b, required st=%0d a=%0d b=%0d sh=%0d ena=%0b sclr_n=%0b done=%0b busy=%0b err=%0b",
               name, $time, got.st, got.a, got.b, got.sh, got.ena, got.sclr_n, got.done, got.busy, got.err,
               exp.st, exp.a, exp.b, exp.sh, exp.ena, exp.sclr_n, exp.done, exp.busy, exp.err);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, required %0d", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sched[d].delete();
      m_cur[d] = IDL;
      m_err[d] = 1'b0;
    end
    m_prev = 1'b0;
  endtask

  task automatic model_edge(input logic s);
    logic rise;
    int   n;
    rise = s && !m_prev;
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? 2 : 4;
      if (m_err[d]) begin
        if (!s) begin
          m_err[d] = 1'b0;
          m_cur[d] = IDL;
        end
      end else if (rise && (m_cur[d].st == 3'd1 || m_cur[d].st == 3'd2)) begin
        m_sched[d].delete();
        m_err[d] = 1'b1;
        m_cur[d] = ER;
      end else begin
        if (rise) begin
          m_sched[d].delete();
          m_sched[d].push_back(CL);
          for (int i = 0; i < n * n; i++) m_sched[d].push_back(calc_rec(i % n, i / n));
          m_sched[d].push_back(DN);
        end
        if (m_sched[d].size() > 0) m_cur[d] = m_sched[d].pop_front();
        else                       m_cur[d] = IDL;
      end
    end
    m_prev = s;
  endtask

  // Called 1 ns after an active edge; returns 1 ns after the next one.
  task automatic step(input logic s);
    start = s;
    @(posedge clk);
    model_edge(s);
    #1;
    chk("model_w8", dut_out(0), m_cur[0]);
    chk("model_w16", dut_out(1), m_cur[1]);
  endtask

  // Asynchronous reset asserted and released between clock edges.
  task automatic do_reset();
    #2 reset_a = 1'b0;
    #1;
    chk("async_reset_w8", dut_out(0), IDL);
    chk("async_reset_w16", dut_out(1), IDL);
    model_reset();
    #78;
    chk("held_reset_w8", dut_out(0), IDL);
    chk("held_reset_w16", dut_out(1), IDL);
    reset_a = 1'b1;
  endtask

  vec_t tbl [39];

  initial begin
    int done_at, max_sh, ncalc, ndone;
    logic s;

    IDL = rec(0, 0, 0, 0, 0, 1, 0, 0, 0);
    CL  = rec(1, 0, 0, 0, 1, 0, 0, 1, 0);
    DN  = rec(3, 0, 0, 0, 0, 1, 1, 0, 0);
    ER  = rec(4, 0, 0, 0, 0, 1, 0, 0, 1);

    // Single operation, abort at k=2, back-to-back via DONE, start held high.
    tbl[0]  = '{1'b1, CL};
    tbl[1]  = '{1'b0, rec(2, 0, 0, 0, 1, 1, 0, 1, 0)};
    tbl[2]  = '{1'b0, rec(2, 1, 0, 1, 1, 1, 0, 1, 0)};
    tbl[3]  = '{1'b0, rec(2, 0, 1, 1, 1, 1, 0, 1, 0)};
    tbl[4]  = '{1'b0, rec(2, 1, 1, 2, 1, 1, 0, 1, 0)};
    tbl[5]  = '{1'b0, DN};
    tbl[6]  = '{1'b0, IDL};
    tbl[7]  = '{1'b1, CL};
    tbl[8]  = '{1'b0, rec(2, 0, 0, 0, 1, 1, 0, 1, 0)};
    tbl[9]  = '{1'b0, rec(2, 1, 0, 1, 1, 1, 0, 1, 0)};
    tbl[10] = '{1'b0, rec(2, 0, 1, 1, 1, 1, 0, 1, 0)};
    tbl[11] = '{1'b1, ER};
    tbl[12] = '{1'b1, ER};
    tbl[13] = '{1'b0, IDL};
    tbl[14] = '{1'b0, IDL};
    tbl[15] = '{1'b1, CL};
    tbl[16] = '{1'b0, rec(2, 0, 0, 0, 1, 1, 0, 1, 0)};
    tbl[17] = '{1'b0, rec(2, 1, 0, 1, 1, 1, 0, 1, 0)};
    tbl[18] = '{1'b0, rec(2, 0, 1, 1, 1, 1, 0, 1, 0)};
    tbl[19] = '{1'b0, rec(2, 1, 1, 2, 1, 1, 0, 1, 0)};
    tbl[20] = '{1'b0, DN};
    tbl[21] = '{1'b1, CL};
    tbl[22] = '{1'b0, rec(2, 0, 0, 0, 1, 1, 0, 1, 0)};
    tbl[23] = '{1'b0, rec(2, 1, 0, 1, 1, 1, 0, 1, 0)};
    tbl[24] = '{1'b0, rec(2, 0, 1, 1, 1, 1, 0, 1, 0)};
    tbl[25] = '{1'b0, rec(2, 1, 1, 2, 1, 1, 0, 1, 0)};
    tbl[26] = '{1'b0, DN};
    tbl[27] = '{1'b0, IDL};
    tbl[28] = '{1'b1, CL};
    tbl[29] = '{1'b1, rec(2, 0, 0, 0, 1, 1, 0, 1, 0)};
    tbl[30] = '{1'b1, rec(2, 1, 0, 1, 1, 1, 0, 1, 0)};
    tbl[31] = '{1'b1, rec(2, 0, 1, 1, 1, 1, 0, 1, 0)};
    tbl[32] = '{1'b1, rec(2, 1, 1, 2, 1, 1, 0, 1, 0)};
    tbl[33] = '{1'b1, DN};
    tbl[34] = '{1'b1, IDL};
    tbl[35] = '{1'b1, IDL};
    tbl[36] = '{1'b1, IDL};
    tbl[37] = '{1'b1, IDL};
    tbl[38] = '{1'b0, IDL};

    reset_a = 1'b1;
    start   = 1'b0;
    model_reset();
    do_reset();

    for (int i = 0; i < 39; i++) begin
      step(tbl[i].s);
      chk($sformatf("table[%0d]", i), dut_out(0), tbl[i].exp);
    end

    // Reset in the middle of CALC, then a full rerun.
    step(1'b1);
    step(1'b0);
    step(1'b0);
    do_reset();
    ndone = 0;
    ncalc = 0;
    step(1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      if (st8 == 3'd2) ncalc++;
      if (done8) ndone++;
    end
    chk_int("rerun_done_pulses", ndone, 1);
    chk_int("rerun_calc_steps", ncalc, 4);

    // Wide instance: 16 steps, shift up to 6, done at E0+17, back-to-back start.
    do_reset();
    done_at = -1;
    max_sh  = 0;
    ncalc   = 0;
    step(1'b1);
    for (int i = 1; i <= 40; i++) begin
      step(1'b0);
      if (st16 == 3'd2) ncalc++;
      if (int'(sh16) > max_sh) max_sh = int'(sh16);
      if (done16) begin
        done_at = i;
        break;
      end
    end
    chk_int("w16_done_edge", done_at, 17);
    chk_int("w16_calc_steps", ncalc, 16);
    chk_int("w16_max_shift", max_sh, 6);
    step(1'b1);
    chk_int("w16_b2b_clr", int'(st16), 1);
    for (int i = 0; i < 20; i++) step(1'b0);

    // Randomised start activity with occasional asynchronous resets.
    s = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) s = ~s;
      if ($urandom_range(0, 99) == 0) begin
        start = s;
        do_reset();
      end else begin
        step(s);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
